uart_matmul_engine: RTL and testbench

//  Parametrised NxN matrix-multiply engine that sits between uart_rx and uart_tx in the top level.

---
 rtl/uart_matmul_engine.sv | 232 +++++++++++++++++++++++
 tb/tb_uart_matmul_engine.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_matmul_engine.sv
// ---------------------------------------------------------------------------
// uart_matmul_engine
//   NxN matrix-multiply engine placed between uart_rx and uart_tx.
//   Collects A then B (row-major, one byte per element) from the rx stream,
//   computes C = A*B with one MAC per cycle, and returns every C element as
//   RES_BYTES bytes, MSB first, paced by the uart_tx busy signal.
//
//   Optional feature macro: MATMUL_SIGNED_EN
//     defined   : elements are DW-bit two's complement, result sign-extended
//     undefined : unsigned arithmetic, result zero-extended
//
// Ports
//   clk       in   system clock
//   rst       in   asynchronous reset, active low
//   rx_data   in   [7:0] received byte (bits above DW ignored)
//   rx_valid  in   one-cycle strobe qualifying rx_data
//   tx_busy   in   uart_tx busy
//   tx_data   out  [7:0] byte to transmit, held until the next tx_start
//   tx_start  out  one-cycle transmit request
//   busy      out  high while computing or sending
//   loading   out  high while a frame is partially received
//   done      out  one-cycle pulse after the last C byte is issued
//   rx_ovf    out  sticky: a byte arrived while the engine could not take it
// ---------------------------------------------------------------------------
module uart_matmul_engine #(
    parameter int N         = 2,
    parameter int DW        = 8,
    parameter int RES_BYTES = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       tx_busy,
    output logic [7:0] tx_data,
    output logic       tx_start,
    output logic       busy,
    output logic       loading,
    output logic       done,
    output logic       rx_ovf
);

    localparam int ACC_W = 2 * DW + $clog2(N) + 1;
    localparam int RES_W = 8 * RES_BYTES;
    localparam int EXT_W = (RES_W > ACC_W) ? RES_W : ACC_W;
    localparam int NE    = N * N;
    localparam int AW    = $clog2(2 * NE);
    localparam int CW    = (N > 1) ? $clog2(N) : 1;
    localparam int BW    = (RES_BYTES > 1) ? $clog2(RES_BYTES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_COMPUTE,
        S_SEND,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    idx_q, idx_d;
    logic [CW-1:0]    i_q, i_d, j_q, j_d, k_q, k_d;
    logic [BW-1:0]    byte_q, byte_d;
    logic             guard_q, guard_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             tx_start_q, tx_start_d;
    logic             rx_ovf_q, rx_ovf_d;
    logic [ACC_W-1:0] acc_q, acc_d;

    // A occupies words 0..NE-1, B occupies NE..2*NE-1, both row-major.
    logic [DW-1:0]    mem [2*NE];
    logic             wr_en;
    logic [AW-1:0]    wr_addr;

    logic [AW-1:0]    a_addr, b_addr;
    logic [ACC_W-1:0] a_ext, b_ext, prod;
    logic [EXT_W-1:0] acc_ext;
    logic [RES_BYTES-1:0][7:0] res_bytes;
    logic [7:0]       tx_byte;

    // Operand fetch and MAC. Multiplying the already-extended operands at
    // ACC_W bits yields the correct low bits for both signed and unsigned.
    always_comb begin
        a_addr = AW'(i_q) * AW'(N) + AW'(k_q);
        b_addr = AW'(NE) + AW'(k_q) * AW'(N) + AW'(j_q);
`ifdef MATMUL_SIGNED_EN
        a_ext   = ACC_W'($signed(mem[a_addr]));
        b_ext   = ACC_W'($signed(mem[b_addr]));
        acc_ext = EXT_W'($signed(acc_q));
`else
        a_ext   = ACC_W'(mem[a_addr]);
        b_ext   = ACC_W'(mem[b_addr]);
        acc_ext = EXT_W'(acc_q);
`endif
        prod      = a_ext * b_ext;
        res_bytes = acc_ext[RES_W-1:0];
        tx_byte   = res_bytes[byte_q];
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        i_d        = i_q;
        j_d        = j_q;
        k_d        = k_q;
        byte_d     = byte_q;
        guard_d    = guard_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        rx_ovf_d   = rx_ovf_q;
        acc_d      = acc_q;
        wr_en      = 1'b0;
        wr_addr    = idx_q;

        case (state_q)
            S_IDLE: begin
                if (rx_valid) begin
                    // Even with N=1 the B byte is still outstanding.
                    wr_en    = 1'b1;
                    wr_addr  = '0;
                    rx_ovf_d = 1'b0;
                    idx_d    = AW'(1);
                    state_d  = S_LOAD;
                end
            end
            S_LOAD: begin
                if (rx_valid) begin
                    wr_en = 1'b1;
                    if (idx_q == AW'(2 * NE - 1)) begin
                        state_d = S_COMPUTE;
                        i_d     = '0;
                        j_d     = '0;
                        k_d     = '0;
                        acc_d   = '0;
                    end else begin
                        idx_d = idx_q + AW'(1);
                    end
                end
            end
            S_COMPUTE: begin
                acc_d = acc_q + prod;
                if (k_q == CW'(N - 1)) begin
                    state_d = S_SEND;
                    byte_d  = BW'(RES_BYTES - 1);
                    guard_d = 1'b0;
                end else begin
                    k_d = k_q + CW'(1);
                end
            end
            S_SEND: begin
                if (!guard_q) begin
                    if (!tx_busy) begin
                        tx_start_d = 1'b1;
                        tx_data_d  = tx_byte;
                        guard_d    = 1'b1;
                    end
                end else begin
                    // Guard cycle: uart_tx has not yet raised busy for the
                    // byte just requested, so tx_busy is not consulted here.
                    guard_d = 1'b0;
                    if (byte_q == '0) begin
                        if (i_q == CW'(N - 1) && j_q == CW'(N - 1)) begin
                            state_d = S_DONE;
                        end else begin
                            state_d = S_COMPUTE;
                            k_d     = '0;
                            acc_d   = '0;
                            if (j_q == CW'(N - 1)) begin
                                j_d = '0;
                                i_d = i_q + CW'(1);
                            end else begin
                                j_d = j_q + CW'(1);
                            end
                        end
                    end else begin
                        byte_d = byte_q - BW'(1);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Bytes arriving while the engine owns the matrices are dropped.
        if (rx_valid && (state_q == S_COMPUTE || state_q == S_SEND || state_q == S_DONE))
            rx_ovf_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            i_q        <= '0;
            j_q        <= '0;
            k_q        <= '0;
            byte_q     <= '0;
            guard_q    <= 1'b0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            rx_ovf_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            i_q        <= i_d;
            j_q        <= j_d;
            k_q        <= k_d;
            byte_q     <= byte_d;
            guard_q    <= guard_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            rx_ovf_q   <= rx_ovf_d;
        end
    end

    // Datapath storage carries no reset; it is always written before use.
    always_ff @(posedge clk) begin
        acc_q <= acc_d;
        if (wr_en)
            mem[wr_addr] <= rx_data[DW-1:0];
    end

    assign tx_data  = tx_data_q;
    assign tx_start = tx_start_q;
    assign busy     = (state_q == S_COMPUTE) || (state_q == S_SEND);
    assign loading  = (state_q == S_LOAD);
    assign done     = (state_q == S_DONE);
    assign rx_ovf   = rx_ovf_q;

endmodule

// File: tb/tb_uart_matmul_engine.sv
// Testbench for uart_matmul_engine (N=2, DW=8, RES_BYTES=3).
// Expected bytes come from a behavioural matrix model and are queued when a
// frame is driven; each test pops them as the DUT emits tx_start pulses.
module tb_uart_matmul_engine;

    localparam int N  = 2;
    localparam int RB = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_busy;
    logic [7:0] tx_data;
    logic       tx_start, busy, loading, done, rx_ovf;

    uart_matmul_engine #(.N(N), .DW(8), .RES_BYTES(RB)) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_busy  (tx_busy),
        .tx_data  (tx_data),
        .tx_start (tx_start),
        .busy     (busy),
        .loading  (loading),
        .done     (done),
        .rx_ovf   (rx_ovf)
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         bad   = 0;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    logic [7:0] fa[N*N];
    logic [7:0] fb[N*N];
    int         viol, first_lat, done_cnt;
    bit         timed_out;

    // Reference model: C = A*B, each element resized to 8*RB bits, MSB first.
    task automatic push_expected();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                longint     acc;
                logic [23:0] r;
                acc = 0;
                for (int k = 0; k < N; k++) begin
`ifdef MATMUL_SIGNED_EN
                    acc += longint'($signed(fa[i*N+k])) * longint'($signed(fb[k*N+j]));
`else
                    acc += longint'(fa[i*N+k]) * longint'(fb[k*N+j]);
`endif
                end
                r = acc[23:0];
                exp_q.push_back(r[23:16]);
                exp_q.push_back(r[15:8]);
                exp_q.push_back(r[7:0]);
            end
    endtask

    // Called #1 after a posedge; returns #1 after the edge that sampled it.
    task automatic drive_byte(input logic [7:0] d);
        rx_data  = d;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic send_frame();
        push_expected();
        for (int i = 0; i < N*N; i++) drive_byte(fa[i]);
        for (int i = 0; i < N*N; i++) drive_byte(fb[i]);
    endtask

    task automatic set_frame1();
        fa = '{8'd1, 8'd2, 8'd3, 8'd4};
        fb = '{8'd5, 8'd6, 8'd7, 8'd8};
    endtask

    // Watches the tx side on negedges, acting as uart_tx. With hold set,
    // tx_busy rises right after each tx_start and stays up 100 cycles.
    // Stops on done, after max_bytes bytes (if nonzero), or at the budget.
    task automatic collect(input int max_bytes, input int budget, input bit hold);
        int cyc;
        int hold_cnt;
        cyc = 0; hold_cnt = 0;
        got_q.delete();
        viol = 0; first_lat = -1; done_cnt = 0; timed_out = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (tx_start) begin
                if (tx_busy) viol++;
                if (first_lat < 0) first_lat = cyc;
                got_q.push_back(tx_data);
                if (hold) hold_cnt = 100;
            end
            if (done) done_cnt++;
            if (hold_cnt > 0) begin
                tx_busy = 1'b1;
                hold_cnt--;
            end else begin
                tx_busy = 1'b0;
            end
            if (done_cnt > 0) break;
            if (max_bytes > 0 && got_q.size() >= max_bytes) break;
            if (cyc >= budget) begin
                timed_out = 1'b1;
                break;
            end
        end
        tx_busy = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; tx_busy = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({tx_data, tx_start, busy, loading, done, rx_ovf} !== 13'h0) begin
            bad++;
            $display("FAIL reset_outputs got=%h exp=0", {tx_data, tx_start, busy, loading, done, rx_ovf});
        end
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if ({tx_data, tx_start, busy, loading, done, rx_ovf} !== 13'h0) begin
            bad++;
            $display("FAIL idle_outputs got=%h exp=0", {tx_data, tx_start, busy, loading, done, rx_ovf});
        end
    endtask

    task automatic test_basic();
        set_frame1();
        push_expected();
        for (int i = 0; i < N*N; i++) begin
            drive_byte(fa[i]);
            if (i == 0) begin
                total++;
                if (loading !== 1'b1 || busy !== 1'b0) begin
                    bad++;
                    $display("FAIL basic_loading got=%b%b exp=10", loading, busy);
                end
            end
        end
        for (int i = 0; i < N*N; i++) drive_byte(fb[i]);
        total++;
        if (busy !== 1'b1 || loading !== 1'b0) begin
            bad++;
            $display("FAIL basic_compute_flags got=%b%b exp=10", busy, loading);
        end
        collect(0, 2000, 1'b0);
        total++;
        if (timed_out || got_q.size() != 4*RB) begin
            bad++;
            $display("FAIL basic_count got=%0d exp=%0d timeout=%0d", got_q.size(), 4*RB, timed_out);
        end
        for (int i = 0; i < got_q.size(); i++) begin
            logic [7:0] e;
            e = 8'hxx;
            if (exp_q.size() > 0) e = exp_q.pop_front();
            total++;
            if (got_q[i] !== e) begin
                bad++;
                $display("FAIL basic_byte%0d got=%h exp=%h", i, got_q[i], e);
            end
        end
        exp_q.delete();
        // Byte sampled at edge 0; tx_start rises at edge N+1 and is seen at
        // negedge N+2 of the count.
        total++;
        if (first_lat - 1 != N + 1) begin
            bad++;
            $display("FAIL basic_latency got=%0d exp=%0d", first_lat - 1, N + 1);
        end
        total++;
        if (done_cnt != 1 || viol != 0) begin
            bad++;
            $display("FAIL basic_done got=%0d/%0d exp=1/0", done_cnt, viol);
        end
        @(negedge clk);
        total++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL basic_done_width got=%b%b exp=00", done, busy);
        end
    endtask

    // All-0xFF frame, then a new frame the cycle right after done.
    task automatic test_back_to_back();
        @(posedge clk); #1;
        fa = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
        fb = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
        send_frame();
        collect(0, 2000, 1'b0);
        total++;
        if (timed_out || got_q.size() != 4*RB || done_cnt != 1) begin
            bad++;
            $display("FAIL ff_count got=%0d exp=%0d", got_q.size(), 4*RB);
        end
        for (int i = 0; i < got_q.size(); i++) begin
            logic [7:0] e;
            e = 8'hxx;
            if (exp_q.size() > 0) e = exp_q.pop_front();
            total++;
            if (got_q[i] !== e) begin
                bad++;
                $display("FAIL ff_byte%0d got=%h exp=%h", i, got_q[i], e);
            end
        end
        exp_q.delete();
        @(posedge clk); #1;
        set_frame1();
        send_frame();
        collect(0, 2000, 1'b0);
        total++;
        if (timed_out || got_q.size() != 4*RB || rx_ovf !== 1'b0) begin
            bad++;
            $display("FAIL b2b_count got=%0d ovf=%b exp=%0d ovf=0", got_q.size(), rx_ovf, 4*RB);
        end
        for (int i = 0; i < got_q.size(); i++) begin
            logic [7:0] e;
            e = 8'hxx;
            if (exp_q.size() > 0) e = exp_q.pop_front();
            total++;
            if (got_q[i] !== e) begin
                bad++;
                $display("FAIL b2b_byte%0d got=%h exp=%h", i, got_q[i], e);
            end
        end
        exp_q.delete();
    endtask

`ifdef MATMUL_SIGNED_EN
    task automatic test_signed();
        @(posedge clk); #1;
        fa = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
        fb = '{8'h01, 8'h01, 8'h01, 8'h01};
        send_frame();
        collect(0, 2000, 1'b0);
        total++;
        if (timed_out || got_q.size() != 4*RB) begin
            bad++;
            $display("FAIL signed_count got=%0d exp=%0d", got_q.size(), 4*RB);
        end
        for (int i = 0; i < got_q.size(); i++) begin
            logic [7:0] e;
            e = 8'hxx;
            if (exp_q.size() > 0) e = exp_q.pop_front();
            total++;
            if (got_q[i] !== e) begin
                bad++;
                $display("FAIL signed_byte%0d got=%h exp=%h", i, got_q[i], e);
            end
        end
        exp_q.delete();
    endtask
`endif

    task automatic test_flow_control();
        @(posedge clk); #1;
        set_frame1();
        send_frame();
        collect(0, 5000, 1'b1);
        total++;
        if (timed_out || got_q.size() != 4*RB || done_cnt != 1) begin
            bad++;
            $display("FAIL flow_count got=%0d exp=%0d timeout=%0d", got_q.size(), 4*RB, timed_out);
        end
        total++;
        if (viol != 0) begin
            bad++;
            $display("FAIL flow_start_while_busy got=%0d exp=0", viol);
        end
        for (int i = 0; i < got_q.size(); i++) begin
            logic [7:0] e;
            e = 8'hxx;
            if (exp_q.size() > 0) e = exp_q.pop_front();
            total++;
            if (got_q[i] !== e) begin
                bad++;
                $display("FAIL flow_byte%0d got=%h exp=%h", i, got_q[i], e);
            end
        end
        exp_q.delete();
    endtask

    task automatic test_overflow();
        @(posedge clk); #1;
        set_frame1();
        send_frame();
        drive_byte(8'h77);  // lands during COMPUTE
        total++;
        if (rx_ovf !== 1'b1) begin
            bad++;
            $display("FAIL ovf_set got=%b exp=1", rx_ovf);
        end
        collect(0, 2000, 1'b0);
        total++;
        if (timed_out || got_q.size() != 4*RB || rx_ovf !== 1'b1) begin
            bad++;
            $display("FAIL ovf_stream got=%0d ovf=%b exp=%0d ovf=1", got_q.size(), rx_ovf, 4*RB);
        end
        for (int i = 0; i < got_q.size(); i++) begin
            logic [7:0] e;
            e = 8'hxx;
            if (exp_q.size() > 0) e = exp_q.pop_front();
            total++;
            if (got_q[i] !== e) begin
                bad++;
                $display("FAIL ovf_byte%0d got=%h exp=%h", i, got_q[i], e);
            end
        end
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (rx_ovf !== 1'b1) begin
            bad++;
            $display("FAIL ovf_sticky got=%b exp=1", rx_ovf);
        end
        push_expected();
        drive_byte(fa[0]);
        total++;
        if (rx_ovf !== 1'b0) begin
            bad++;
            $display("FAIL ovf_clear got=%b exp=0", rx_ovf);
        end
        for (int i = 1; i < N*N; i++) drive_byte(fa[i]);
        for (int i = 0; i < N*N; i++) drive_byte(fb[i]);
        collect(0, 2000, 1'b0);
        for (int i = 0; i < got_q.size(); i++) begin
            logic [7:0] e;
            e = 8'hxx;
            if (exp_q.size() > 0) e = exp_q.pop_front();
            total++;
            if (got_q[i] !== e) begin
                bad++;
                $display("FAIL ovf_next_byte%0d got=%h exp=%h", i, got_q[i], e);
            end
        end
        total++;
        if (got_q.size() != 4*RB) begin
            bad++;
            $display("FAIL ovf_next_count got=%0d exp=%0d", got_q.size(), 4*RB);
        end
        exp_q.delete();
    endtask

    task automatic test_reset_mid_send();
        @(posedge clk); #1;
        set_frame1();
        send_frame();
        collect(4, 2000, 1'b0);
        // Sitting in the negedge where the 4th tx_start is visible.
        rst = 1'b0;
        #1;
        total++;
        if ({tx_data, tx_start, busy, loading, done, rx_ovf} !== 13'h0) begin
            bad++;
            $display("FAIL midsend_reset got=%h exp=0", {tx_data, tx_start, busy, loading, done, rx_ovf});
        end
        for (int i = 0; i < got_q.size(); i++) begin
            logic [7:0] e;
            e = 8'hxx;
            if (exp_q.size() > 0) e = exp_q.pop_front();
            total++;
            if (got_q[i] !== e) begin
                bad++;
                $display("FAIL midsend_partial%0d got=%h exp=%h", i, got_q[i], e);
            end
        end
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        send_frame();
        collect(0, 2000, 1'b0);
        total++;
        if (timed_out || got_q.size() != 4*RB || done_cnt != 1) begin
            bad++;
            $display("FAIL midsend_after_count got=%0d exp=%0d", got_q.size(), 4*RB);
        end
        for (int i = 0; i < got_q.size(); i++) begin
            logic [7:0] e;
            e = 8'hxx;
            if (exp_q.size() > 0) e = exp_q.pop_front();
            total++;
            if (got_q[i] !== e) begin
                bad++;
                $display("FAIL midsend_after_byte%0d got=%h exp=%h", i, got_q[i], e);
            end
        end
        exp_q.delete();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
`ifdef MATMUL_SIGNED_EN
        test_signed();
`endif
        test_flow_control();
        test_overflow();
        test_reset_mid_send();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
